// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width and the serial-unit state encoding.
package alu_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_sub.sv
// 1-bit full subtractor cell, the subtract-side counterpart of the adder's full-adder.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when a < b, or when a == b and a borrow is already pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub8.sv
// Bit-serial subtractor D = A1 - A2 - in, LSB first through one full_sub cell,
// with start/done handshake and borrow, zero and signed-overflow flags.
module serial_sub8
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] A2,
  input  logic             in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             B,
  output logic             Z,
  output logic             V
);

  localparam int            CW      = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t           state_r;
  state_t           state_nx_s;
  logic             load_s;
  logic             last_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic             br_r;
  logic [WIDTH-1:0] acc_r;
  logic [CW-1:0]    cnt_r;
  logic             a_msb_r;
  logic             b_msb_r;
  logic             d_s;
  logic             bout_s;
  logic [WIDTH-1:0] res_s;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] d_r;
  logic             b_r;
  logic             z_r;
  logic             v_r;

  full_sub u_cell (
    .a    (a_sh_r[0]),
    .b    (b_sh_r[0]),
    .bin  (br_r),
    .d    (d_s),
    .bout (bout_s)
  );

  assign last_s = (cnt_r == LAST);
  assign res_s  = {d_s, acc_r[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; DONE accepts a new start just like IDLE.
  always_comb begin
    state_nx_s = state_r;
    load_s     = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          load_s     = 1'b1;
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Operand shifting, serial accumulation, and result/flag capture on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      br_r    <= 1'b0;
      acc_r   <= '0;
      cnt_r   <= '0;
      a_msb_r <= 1'b0;
      b_msb_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      d_r     <= '0;
      b_r     <= 1'b0;
      z_r     <= 1'b0;
      v_r     <= 1'b0;
    end else begin
      busy_r <= (state_nx_s == RUN);
      done_r <= (state_nx_s == DONE);
      if (load_s) begin
        a_sh_r  <= A1;
        b_sh_r  <= A2;
        br_r    <= in;
        acc_r   <= '0;
        cnt_r   <= '0;
        a_msb_r <= A1[WIDTH-1];
        b_msb_r <= A2[WIDTH-1];
      end else if (state_r == RUN) begin
        a_sh_r <= a_sh_r >> 1;
        b_sh_r <= b_sh_r >> 1;
        br_r   <= bout_s;
        acc_r  <= res_s;
        cnt_r  <= cnt_r + CNT_ONE;
        // Operand sign bits were saved at load since the shifters have consumed them.
        if (last_s) begin
          d_r <= res_s;
          b_r <= bout_s;
          z_r <= (res_s == '0);
          v_r <= (a_msb_r != b_msb_r) && (d_s != a_msb_r);
        end
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign D    = d_r;
  assign B    = b_r;
  assign Z    = z_r;
  assign V    = v_r;

endmodule

// File: tb/tb_serial_sub8.sv
// Directed bench for serial_sub8: arithmetic model feeds a scoreboard, checked at each done pulse.
module tb_serial_sub8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] A1;
  logic [7:0] A2;
  logic       in;
  logic       busy;
  logic       done;
  logic [7:0] D;
  logic       B;
  logic       Z;
  logic       V;

  typedef struct packed {
    logic [7:0] d;
    logic       b;
    logic       z;
    logic       v;
  } res_t;

  res_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  serial_sub8 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A1    (A1),
    .A2    (A2),
    .in    (in),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .B     (B),
    .Z     (Z),
    .V     (V)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(input logic [7:0] a1, input logic [7:0] a2, input logic bin);
    res_t       r;
    logic [8:0] t;
    t   = {1'b0, a1} - {1'b0, a2} - {8'd0, bin};
    r.d = t[7:0];
    r.b = t[8];
    r.z = (t[7:0] == 8'd0);
    r.v = (a1[7] != a2[7]) && (t[7] != a1[7]);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands with start for one cycle; afterwards scramble the inputs.
  task automatic launch(input logic [7:0] a1, input logic [7:0] a2, input logic bin);
    A1    = a1;
    A2    = a2;
    in    = bin;
    start = 1'b1;
    sb.push_back(model(a1, a2, bin));
    @(negedge clk);
    start = 1'b0;
    A1    = 8'hA5;
    A2    = 8'h5A;
    in    = 1'b1;
  endtask

  // Cycles 1..8 of an operation; optionally fires an ignored start at cycle 3.
  task automatic expect_run(input string tag, input logic [7:0] held, input bit inject);
    for (int c = 1; c <= 8; c++) begin
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      check({tag, "_nodone"}, {31'd0, done}, 32'd0);
      if (c == 1 || c == 8) check({tag, "_hold"}, {24'd0, D}, {24'd0, held});
      if (inject && c == 3) begin
        start = 1'b1;
        A1    = 8'hFF;
        A2    = 8'hFF;
      end else if (inject && c == 4) begin
        start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic expect_done(input string tag);
    res_t e;
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_D"}, {24'd0, D}, {24'd0, e.d});
      check({tag, "_B"}, {31'd0, B}, {31'd0, e.b});
      check({tag, "_Z"}, {31'd0, Z}, {31'd0, e.z});
      check({tag, "_V"}, {31'd0, V}, {31'd0, e.v});
    end
  endtask

  task automatic full_op(input string tag, input logic [7:0] a1, input logic [7:0] a2,
                         input logic bin, input logic [7:0] held);
    launch(a1, a2, bin);
    expect_run(tag, held, 1'b0);
    expect_done(tag);
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    A1    = 8'h00;
    A2    = 8'h00;
    in    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_D", {24'd0, D}, 32'd0);
    check("rst_B", {31'd0, B}, 32'd0);
    check("rst_Z", {31'd0, Z}, 32'd0);
    check("rst_V", {31'd0, V}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    full_op("t59_9e", 8'h59, 8'h9E, 1'b0, 8'h00);
    full_op("t67_67", 8'h67, 8'h67, 1'b0, 8'hBB);
    full_op("t67_67b", 8'h67, 8'h67, 1'b1, 8'h00);
    full_op("t80_01", 8'h80, 8'h01, 1'b0, 8'hFF);
    full_op("t00_01b", 8'h00, 8'h01, 1'b1, 8'h7F);

    // Start during RUN must be ignored and yield exactly one done.
    launch(8'h92, 8'h00, 1'b0);
    expect_run("ign", 8'hFE, 1'b1);
    expect_done("ign");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("ign_once", {31'd0, done}, 32'd0);
    end

    // Reset in the middle of an operation.
    launch(8'h59, 8'h9E, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_D", {24'd0, D}, 32'd0);
    check("mid_rst_B", {31'd0, B}, 32'd0);
    sb.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("mid_rst_nodone", {31'd0, done}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    launch(8'h10, 8'h01, 1'b0);
    expect_run("post_rst", 8'h00, 1'b0);
    expect_done("post_rst");

    // Back-to-back: new start in the DONE cycle; previous D held until next done.
    launch(8'h05, 8'h03, 1'b0);
    expect_run("b2b", 8'h0F, 1'b0);
    expect_done("b2b");
    @(negedge clk);
    check("b2b_pulse", {31'd0, done}, 32'd0);
    check("b2b_sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
